nn_burst_feeder: RTL



---
 rtl/nn_pkg.sv | 25 ++
 rtl/nn_row_packer.sv | 44 ++++
 rtl/nn_burst_feeder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared constants for the NN burst feeder and the NN controller that consumes its lane bus:
// geometry of the feature/weight bursts and the feeder state encoding.
package nn_pkg;

  localparam int BYTE_W     = 8;
  localparam int LANES      = 50;
  localparam int FEAT_BEATS = 20;
  localparam int L0_BEATS   = 21;
  localparam int L1_BEATS   = 3;
  localparam int L0_NEURONS = 100;
  localparam int L1_NEURONS = 2;
  localparam int GAP_L0     = 24;
  localparam int GAP_L1     = 6;

  typedef logic [2:0] feed_state_t;

  localparam feed_state_t ST_IDLE = 3'd0;
  localparam feed_state_t ST_FEAT = 3'd1;
  localparam feed_state_t ST_W0   = 3'd2;
  localparam feed_state_t ST_GAP0 = 3'd3;
  localparam feed_state_t ST_W1   = 3'd4;
  localparam feed_state_t ST_GAP1 = 3'd5;
  localparam feed_state_t ST_DONE = 3'd6;

endpackage

// File: rtl/nn_row_packer.sv
// Byte-to-row packer: fills lanes 1..LANES in arrival order and presents the full row
// combinationally on the accept that fills the last lane.
module nn_row_packer
  import nn_pkg::*;
#(
  parameter int LANES = nn_pkg::LANES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BYTE_W-1:0]       i_byte,
  input  logic                    i_accept,
  input  logic                    i_clear,
  output logic [LANES*BYTE_W-1:0] o_row,
  output logic                    o_row_done
);

  localparam int IDX_W = $clog2(LANES);

  logic [IDX_W-1:0]            r_idx;
  logic [(LANES-1)*BYTE_W-1:0] r_stage;
  logic                        w_last;

  assign w_last     = (r_idx == IDX_W'(LANES - 1));
  assign o_row_done = i_accept && w_last;
  // The last lane is never staged: it is taken straight from the byte being accepted.
  assign o_row      = {i_byte, r_stage};

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_idx <= '0;
    end else if (i_accept) begin
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  // NOTE: the staging row has no reset; every lane is rewritten before a row can be released.
  always_ff @(posedge clk) begin
    if (i_accept && !w_last) begin
      r_stage[r_idx*BYTE_W +: BYTE_W] <= i_byte;
    end
  end

endmodule

// File: rtl/nn_burst_feeder.sv
// Transmit side of the lane burst interface: feature burst, layer-0 and layer-1 weight bursts
// with compute gaps. Define NNFEED_CHECKSUM_EN to add the csum output (byte sum of the frame).
module nn_burst_feeder
  import nn_pkg::*;
#(
  parameter int LANES      = nn_pkg::LANES,
  parameter int FEAT_BEATS = nn_pkg::FEAT_BEATS,
  parameter int L0_NEURONS = nn_pkg::L0_NEURONS,
  parameter int L0_BEATS   = nn_pkg::L0_BEATS,
  parameter int L1_NEURONS = nn_pkg::L1_NEURONS,
  parameter int L1_BEATS   = nn_pkg::L1_BEATS,
  parameter int GAP_L0     = nn_pkg::GAP_L0,
  parameter int GAP_L1     = nn_pkg::GAP_L1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BYTE_W-1:0]       s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [7:0]              count,
  output logic [LANES*BYTE_W-1:0] lanes,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    done
`ifdef NNFEED_CHECKSUM_EN
  ,
  output logic [15:0]             csum
`endif
);

  feed_state_t             r_state;
  logic [7:0]              r_beat;
  logic [7:0]              r_neuron;
  logic [7:0]              r_gap;
  logic                    w_accept;
  logic                    w_start;
  logic                    w_row_done;
  logic                    w_last_beat;
  logic [LANES*BYTE_W-1:0] w_row;

  assign s_ready  = (r_state == ST_FEAT) || (r_state == ST_W0) || (r_state == ST_W1);
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign w_accept = s_valid && s_ready;
  assign w_start  = start && (r_state == ST_IDLE);

  nn_row_packer #(
    .LANES (LANES)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_byte     (s_data),
    .i_accept   (w_accept),
    .i_clear    (w_start),
    .o_row      (w_row),
    .o_row_done (w_row_done)
  );

  always_comb begin
    // NOTE: default first so no path through the case leaves the signal unassigned (no latch).
    w_last_beat = 1'b0;
    case (r_state)
      ST_FEAT: w_last_beat = (r_beat == 8'(FEAT_BEATS - 1));
      ST_W0:   w_last_beat = (r_beat == 8'(L0_BEATS - 1));
      ST_W1:   w_last_beat = (r_beat == 8'(L1_BEATS - 1));
      default: w_last_beat = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_beat   <= '0;
      r_neuron <= '0;
      r_gap    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state  <= ST_FEAT;
            r_beat   <= '0;
            r_neuron <= '0;
            r_gap    <= '0;
          end
        end
        ST_FEAT, ST_W0, ST_W1: begin
          if (w_row_done) begin
            r_beat <= w_last_beat ? '0 : r_beat + 8'd1;
            if (w_last_beat) begin
              r_gap <= '0;
              if (r_state == ST_FEAT)    r_state <= ST_W0;
              else if (r_state == ST_W0) r_state <= ST_GAP0;
              else                       r_state <= ST_GAP1;
            end
          end
        end
        ST_GAP0: begin
          if (r_gap == 8'(GAP_L0 - 1)) begin
            r_gap <= '0;
            if (r_neuron == 8'(L0_NEURONS - 1)) begin
              r_neuron <= '0;
              r_state  <= ST_W1;
            end else begin
              r_neuron <= r_neuron + 8'd1;
              r_state  <= ST_W0;
            end
          end else begin
            r_gap <= r_gap + 8'd1;
          end
        end
        ST_GAP1: begin
          if (r_gap == 8'(GAP_L1 - 1)) begin
            r_gap <= '0;
            if (r_neuron == 8'(L1_NEURONS - 1)) begin
              r_state <= ST_DONE;
            end else begin
              r_neuron <= r_neuron + 8'd1;
              r_state  <= ST_W1;
            end
          end else begin
            r_gap <= r_gap + 8'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Row and beat index hold between beats so the consumer may resample them every clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      lanes     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= w_row_done;
      if (w_row_done) begin
        count <= r_beat;
        lanes <= w_row;
      end
    end
  end

`ifdef NNFEED_CHECKSUM_EN
  logic [15:0] r_csum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_csum <= '0;
    end else if (w_start) begin
      r_csum <= '0;
    end else if (w_accept) begin
      r_csum <= r_csum + 16'(s_data);
    end
  end

  assign csum = r_csum;
`endif

endmodule
